kt_cmd_sched: RTL and testbench

Command scheduler between the two command sources of the Knight's Tour robot and the single cmd_proc datapath. It accepts 16-bit commands from the remote (UART) side and from the tour-logic side, and issues exactly one command at a time to cmd_proc. It waits for completion or a timeout, then routes the 8-bit response back to the requester that owns the command. A remote tour-start command locks the datapath to the tour side until the tour finishes.

---
 rtl/kt_cmd_pkg.sv | 27 ++
 rtl/kt_tmo_cnt.sv | 38 +++
 rtl/kt_cmd_sched.sv | 175 +++++++++++++++++
 tb/tb_kt_cmd_sched.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kt_cmd_pkg.sv
// Shared opcode, response and state definitions for the
// Knight's Tour command scheduler.
package kt_cmd_pkg;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;

  localparam logic [3:0] OP_TOUR  = 4'h6;
  localparam logic [7:0] RSP_DONE = 8'hA5;
  localparam logic [7:0] RSP_TMO  = 8'h5A;

  typedef enum logic {
    OWN_RMT,
    OWN_TOUR
  } owner_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } sched_state_t;

  function automatic logic is_tour_op(input logic [15:0] c);
    return c[OP_MSB:OP_LSB] == OP_TOUR;
  endfunction

endpackage

// File: rtl/kt_tmo_cnt.sv
// Clearable up-counter that flags the last cycle of the
// command timeout window.
module kt_tmo_cnt
  import kt_cmd_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 33554432,
  parameter int unsigned TMO_W      = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/kt_cmd_sched.sv
// Arbitrates remote and tour commands onto cmd_proc, one at
// a time, and routes each response back to its owner.
module kt_cmd_sched
  import kt_cmd_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 33554432,
  parameter int unsigned TMO_W      = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rmt_vld,
  input  logic [15:0] rmt_cmd,
  output logic        rmt_ack,
  input  logic        tour_vld,
  input  logic [15:0] tour_cmd,
  output logic        tour_ack,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        rmt_resp_vld,
  output logic        tour_resp_vld,
  output logic        tour_go,
  output logic [7:0]  tour_pos,
  input  logic        tour_fin,
  output logic        tour_lock,
  output logic        busy
);

  sched_state_t state_q, state_d;
  owner_t       owner_q, owner_d;
  logic [15:0]  cmd_q, cmd_d;
  logic [7:0]   resp_q, resp_d;
  logic [7:0]   pos_q, pos_d;
  logic         rdy_q, rdy_d;
  logic         rack_q, rack_d;
  logic         tack_q, tack_d;
  logic         rrv_q, rrv_d;
  logic         trv_q, trv_d;
  logic         go_q, go_d;
  logic         lock_q, lock_d;
  logic         pend_q, pend_d;
  logic         cnt_clr;
  logic         tmo_exp;

  kt_tmo_cnt #(
    .TMO_CYCLES(TMO_CYCLES),
    .TMO_W     (TMO_W)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (state_q == WAIT),
    .expire_o(tmo_exp)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    resp_d  = resp_q;
    pos_d   = pos_q;
    rdy_d   = rdy_q;
    lock_d  = lock_q;
    pend_d  = pend_q;
    rack_d  = 1'b0;
    tack_d  = 1'b0;
    rrv_d   = 1'b0;
    trv_d   = 1'b0;
    go_d    = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (lock_q && (tour_fin || pend_q)) begin
          lock_d = 1'b0;
          rrv_d  = 1'b1;
          resp_d = RSP_DONE;
        end else if (!lock_q && rmt_vld) begin
          rack_d = 1'b1;
          if (is_tour_op(rmt_cmd)) begin
            go_d   = 1'b1;
            pos_d  = rmt_cmd[7:0];
            lock_d = 1'b1;
          end else begin
            cmd_d   = rmt_cmd;
            owner_d = OWN_RMT;
            rdy_d   = 1'b1;
            state_d = WAIT;
            cnt_clr = 1'b1;
          end
        end else if (tour_vld) begin
          tack_d  = 1'b1;
          cmd_d   = tour_cmd;
          owner_d = OWN_TOUR;
          rdy_d   = 1'b1;
          state_d = WAIT;
          cnt_clr = 1'b1;
        end
      end
      WAIT: begin
        if (tour_fin && lock_q)
          pend_d = 1'b1;
        if (clr_cmd_rdy)
          rdy_d = 1'b0;
        // send_resp beats an expiry landing on the same cycle
        if (send_resp || tmo_exp) begin
          state_d = RESP;
          rdy_d   = 1'b0;
          resp_d  = send_resp ? RSP_DONE : RSP_TMO;
          rrv_d   = (owner_q == OWN_RMT);
          trv_d   = (owner_q == OWN_TOUR);
        end
      end
      RESP: begin
        state_d = IDLE;
        if (tour_fin && lock_q)
          pend_d = 1'b1;
        // a stuck tour command aborts the tour; tell the remote
        if (owner_q == OWN_TOUR && resp_q == RSP_TMO) begin
          lock_d = 1'b0;
          pend_d = 1'b0;
          rrv_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_RMT;
      cmd_q   <= '0;
      resp_q  <= '0;
      pos_q   <= '0;
      rdy_q   <= 1'b0;
      rack_q  <= 1'b0;
      tack_q  <= 1'b0;
      rrv_q   <= 1'b0;
      trv_q   <= 1'b0;
      go_q    <= 1'b0;
      lock_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      resp_q  <= resp_d;
      pos_q   <= pos_d;
      rdy_q   <= rdy_d;
      rack_q  <= rack_d;
      tack_q  <= tack_d;
      rrv_q   <= rrv_d;
      trv_q   <= trv_d;
      go_q    <= go_d;
      lock_q  <= lock_d;
      pend_q  <= pend_d;
    end
  end

  assign rmt_ack       = rack_q;
  assign tour_ack      = tack_q;
  assign cmd           = cmd_q;
  assign cmd_rdy       = rdy_q;
  assign resp          = resp_q;
  assign rmt_resp_vld  = rrv_q;
  assign tour_resp_vld = trv_q;
  assign tour_go       = go_q;
  assign tour_pos      = pos_q;
  assign tour_lock     = lock_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_kt_cmd_sched.sv
// Scenario bench for kt_cmd_sched with a transaction-level
// scoreboard for randomized traffic.
module tb_kt_cmd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        rmt_vld, tour_vld;
  logic [15:0] rmt_cmd, tour_cmd;
  logic        rmt_ack, tour_ack;
  logic [15:0] cmd;
  logic        cmd_rdy, clr_cmd_rdy, send_resp;
  logic [7:0]  resp, tour_pos;
  logic        rmt_resp_vld, tour_resp_vld;
  logic        tour_go, tour_fin, tour_lock, busy;
  logic [39:0] outs;

  int n_run  = 0;
  int n_fail = 0;

  kt_cmd_sched #(.TMO_CYCLES(16), .TMO_W(5)) dut (
    .clk(clk), .rst(rst),
    .rmt_vld(rmt_vld), .rmt_cmd(rmt_cmd), .rmt_ack(rmt_ack),
    .tour_vld(tour_vld), .tour_cmd(tour_cmd), .tour_ack(tour_ack),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp(resp),
    .rmt_resp_vld(rmt_resp_vld), .tour_resp_vld(tour_resp_vld),
    .tour_go(tour_go), .tour_pos(tour_pos), .tour_fin(tour_fin),
    .tour_lock(tour_lock), .busy(busy)
  );

  always #5 clk = ~clk;

  assign outs = {rmt_ack, tour_ack, cmd, cmd_rdy, resp,
                 rmt_resp_vld, tour_resp_vld, tour_go,
                 tour_pos, tour_lock, busy};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_run++;
    if (outs !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0", outs);
    end
    rst = 1'b0;
    tick();
    n_run++;
    if (outs !== 40'h0) begin
      n_fail++;
      $display("FAIL idle_outs: got %h want 0", outs);
    end
  endtask

  task automatic test_single();
    rmt_vld = 1'b1; rmt_cmd = 16'h2000;
    tick();
    n_run++;
    if ({rmt_ack, tour_ack, cmd_rdy, busy, cmd} !== {4'b1011, 16'h2000}) begin
      n_fail++;
      $display("FAIL single_grant: got %b %h want 1011 2000",
               {rmt_ack, tour_ack, cmd_rdy, busy}, cmd);
    end
    rmt_vld = 1'b0; clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    n_run++;
    if ({rmt_ack, cmd_rdy, busy, cmd} !== {3'b001, 16'h2000}) begin
      n_fail++;
      $display("FAIL single_clr: got %b %h want 001 2000",
               {rmt_ack, cmd_rdy, busy}, cmd);
    end
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    n_run++;
    if ({rmt_resp_vld, tour_resp_vld, resp} !== {2'b10, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_resp: got %b %h want 10 a5",
               {rmt_resp_vld, tour_resp_vld}, resp);
    end
    tick();
    n_run++;
    if ({rmt_resp_vld, busy, resp} !== {2'b00, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_idle: got %b %h want 00 a5",
               {rmt_resp_vld, busy}, resp);
    end
  endtask

  task automatic test_priority();
    rmt_vld = 1'b1; rmt_cmd = 16'h4BF1;
    tour_vld = 1'b1; tour_cmd = 16'h4002;
    tick();
    n_run++;
    if ({rmt_ack, tour_ack, cmd_rdy, cmd} !== {3'b101, 16'h4BF1}) begin
      n_fail++;
      $display("FAIL prio_rmt: got %b %h want 101 4bf1",
               {rmt_ack, tour_ack, cmd_rdy}, cmd);
    end
    rmt_vld = 1'b0; send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    n_run++;
    if ({rmt_resp_vld, tour_resp_vld, cmd_rdy, resp} !== {3'b100, 8'hA5}) begin
      n_fail++;
      $display("FAIL prio_resp: got %b %h want 100 a5",
               {rmt_resp_vld, tour_resp_vld, cmd_rdy}, resp);
    end
    tick();
    n_run++;
    if ({tour_ack, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL prio_gap: got %b want 00", {tour_ack, busy});
    end
    tick();
    n_run++;
    if ({tour_ack, cmd_rdy, cmd} !== {2'b11, 16'h4002}) begin
      n_fail++;
      $display("FAIL prio_tour: got %b %h want 11 4002",
               {tour_ack, cmd_rdy}, cmd);
    end
    tour_vld = 1'b0; clr_cmd_rdy = 1'b1; send_resp = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    n_run++;
    if ({tour_resp_vld, rmt_resp_vld, cmd_rdy, resp} !== {3'b100, 8'hA5}) begin
      n_fail++;
      $display("FAIL prio_tresp: got %b %h want 100 a5",
               {tour_resp_vld, rmt_resp_vld, cmd_rdy}, resp);
    end
    tick();
  endtask

  task automatic test_tour_lock();
    int acks;
    rmt_vld = 1'b1; rmt_cmd = 16'h6022;
    tick();
    n_run++;
    if ({rmt_ack, tour_go, tour_lock, cmd_rdy, busy, tour_pos}
        !== {5'b11100, 8'h22}) begin
      n_fail++;
      $display("FAIL lock_go: got %b %h want 11100 22",
               {rmt_ack, tour_go, tour_lock, cmd_rdy, busy}, tour_pos);
    end
    rmt_vld = 1'b0;
    tick();
    rmt_vld = 1'b1; rmt_cmd = 16'h4BF1;
    tour_vld = 1'b1; tour_cmd = 16'h4002;
    tick();
    n_run++;
    if ({tour_go, rmt_ack, tour_ack, cmd} !== {3'b001, 16'h4002}) begin
      n_fail++;
      $display("FAIL lock_tour: got %b %h want 001 4002",
               {tour_go, rmt_ack, tour_ack}, cmd);
    end
    tour_vld = 1'b0; send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    n_run++;
    if ({tour_resp_vld, rmt_resp_vld, resp} !== {2'b10, 8'hA5}) begin
      n_fail++;
      $display("FAIL lock_tresp: got %b %h want 10 a5",
               {tour_resp_vld, rmt_resp_vld}, resp);
    end
    acks = 0;
    repeat (4) begin
      tick();
      if (rmt_ack) acks++;
    end
    n_run++;
    if (acks != 0 || tour_lock !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_stall: got acks=%0d lock=%b want 0 1", acks, tour_lock);
    end
    tour_fin = 1'b1;
    tick();
    tour_fin = 1'b0;
    n_run++;
    if ({rmt_resp_vld, tour_lock, rmt_ack, resp} !== {3'b100, 8'hA5}) begin
      n_fail++;
      $display("FAIL lock_fin: got %b %h want 100 a5",
               {rmt_resp_vld, tour_lock, rmt_ack}, resp);
    end
    tick();
    n_run++;
    if ({rmt_ack, cmd_rdy, cmd} !== {2'b11, 16'h4BF1}) begin
      n_fail++;
      $display("FAIL lock_release: got %b %h want 11 4bf1",
               {rmt_ack, cmd_rdy}, cmd);
    end
    rmt_vld = 1'b0; send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int k;
    logic seen, rdy15;
    tour_vld = 1'b1; tour_cmd = 16'h4002;
    tick();
    n_run++;
    if (tour_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_grant: got %b want 1", tour_ack);
    end
    tour_vld = 1'b0;
    k = 0; seen = 1'b0; rdy15 = 1'b0;
    while (k < 40 && !seen) begin
      tick();
      k++;
      if (k == 15) rdy15 = cmd_rdy;
      if (tour_resp_vld) seen = 1'b1;
    end
    n_run++;
    if (!seen || k != 16 || resp !== 8'h5A || cmd_rdy !== 1'b0 || rdy15 !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_expire: got seen=%b cyc=%0d resp=%h rdy=%b rdy15=%b want 1 16 5a 0 1",
               seen, k, resp, cmd_rdy, rdy15);
    end
    tick();
    n_run++;
    if ({rmt_resp_vld, tour_resp_vld, tour_lock, busy, resp} !== {4'b1000, 8'h5A}) begin
      n_fail++;
      $display("FAIL tmo_abort: got %b %h want 1000 5a",
               {rmt_resp_vld, tour_resp_vld, tour_lock, busy}, resp);
    end
    rmt_vld = 1'b1; rmt_cmd = 16'h1234;
    tick();
    rmt_vld = 1'b0;
    repeat (15) tick();
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    n_run++;
    if ({rmt_resp_vld, resp} !== {1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL tmo_race: got %b %h want 1 a5", rmt_resp_vld, resp);
    end
    tick();
  endtask

  task automatic test_fin_pending();
    int early;
    rmt_vld = 1'b1; rmt_cmd = 16'h6033;
    tick();
    rmt_vld = 1'b0;
    tour_vld = 1'b1; tour_cmd = 16'h4555;
    tick();
    n_run++;
    if ({tour_ack, tour_lock, tour_pos} !== {2'b11, 8'h33}) begin
      n_fail++;
      $display("FAIL pend_grant: got %b %h want 11 33", {tour_ack, tour_lock}, tour_pos);
    end
    tour_vld = 1'b0;
    tick();
    tour_fin = 1'b1;
    tick();
    tour_fin = 1'b0;
    early = 0;
    repeat (3) begin
      tick();
      if (rmt_resp_vld) early++;
    end
    n_run++;
    if (early != 0 || tour_lock !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_hold: got early=%0d lock=%b want 0 1", early, tour_lock);
    end
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    n_run++;
    if ({tour_resp_vld, rmt_resp_vld, resp} !== {2'b10, 8'hA5}) begin
      n_fail++;
      $display("FAIL pend_tresp: got %b %h want 10 a5",
               {tour_resp_vld, rmt_resp_vld}, resp);
    end
    tick();
    n_run++;
    if ({rmt_resp_vld, tour_lock} !== 2'b01) begin
      n_fail++;
      $display("FAIL pend_idle: got %b want 01", {rmt_resp_vld, tour_lock});
    end
    tick();
    n_run++;
    if ({rmt_resp_vld, tour_lock, resp} !== {2'b10, 8'hA5}) begin
      n_fail++;
      $display("FAIL pend_fire: got %b %h want 10 a5", {rmt_resp_vld, tour_lock}, resp);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int stray;
    rmt_vld = 1'b1; rmt_cmd = 16'h6044;
    tick();
    rmt_vld = 1'b0;
    tour_vld = 1'b1; tour_cmd = 16'h4777;
    tick();
    tour_vld = 1'b0;
    tick();
    n_run++;
    if ({busy, cmd_rdy, tour_lock} !== 3'b111) begin
      n_fail++;
      $display("FAIL rst_setup: got %b want 111", {busy, cmd_rdy, tour_lock});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_run++;
    if (outs !== 40'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got %h want 0", outs);
    end
    send_resp = 1'b1; clr_cmd_rdy = 1'b1;
    tick();
    send_resp = 1'b0; clr_cmd_rdy = 1'b0;
    stray = (rmt_resp_vld || tour_resp_vld) ? 1 : 0;
    repeat (3) begin
      tick();
      if (rmt_resp_vld || tour_resp_vld || busy) stray++;
    end
    n_run++;
    if (stray != 0 || resp !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_stray: got stray=%0d resp=%h want 0 00", stray, resp);
    end
  endtask

  task automatic test_random();
    logic [16:0] q[$];
    for (int r = 0; r < 30; r++) begin
      logic [15:0] rc, tc, ec;
      logic        eo, got, seen, tmo;
      int          pat, w, d, c, k, lat;
      logic [7:0]  ersp;
      rc = 16'($urandom);
      if (rc[15:12] == 4'h6) rc[15:12] = 4'h3;
      tc = 16'($urandom);
      pat = $urandom_range(1, 3);
      if (pat == 1 || pat == 3) begin
        rmt_vld = 1'b1; rmt_cmd = rc; q.push_back({1'b0, rc});
      end
      if (pat == 2 || pat == 3) begin
        tour_vld = 1'b1; tour_cmd = tc; q.push_back({1'b1, tc});
      end
      while (q.size() != 0) begin
        {eo, ec} = q.pop_front();
        w = 0; got = 1'b0;
        while (w < 6 && !got) begin
          tick();
          w++;
          if (rmt_ack || tour_ack) got = 1'b1;
        end
        n_run++;
        if (!got || {rmt_ack, tour_ack} !== (eo ? 2'b01 : 2'b10)
            || cmd !== ec || cmd_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_grant: got ack=%b cmd=%h want owner=%b cmd=%h",
                   {rmt_ack, tour_ack}, cmd, eo, ec);
        end
        if (eo) tour_vld = 1'b0;
        else    rmt_vld  = 1'b0;
        d = $urandom_range(0, 20);
        c = $urandom_range(0, 20);
        tmo  = (d > 15);
        lat  = tmo ? 16 : d + 1;
        ersp = tmo ? 8'h5A : 8'hA5;
        k = 0; seen = 1'b0;
        while (k < 40 && !seen) begin
          if (k == d) send_resp = 1'b1;
          if (k == c) clr_cmd_rdy = 1'b1;
          tick();
          send_resp = 1'b0; clr_cmd_rdy = 1'b0;
          k++;
          if (rmt_resp_vld || tour_resp_vld) seen = 1'b1;
        end
        n_run++;
        if (!seen || k != lat || resp !== ersp || cmd_rdy !== 1'b0
            || {rmt_resp_vld, tour_resp_vld} !== (eo ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL rand_resp: got cyc=%0d vld=%b resp=%h want cyc=%0d owner=%b resp=%h",
                   k, {rmt_resp_vld, tour_resp_vld}, resp, lat, eo, ersp);
        end
        if (eo && tmo) begin
          tick();
          n_run++;
          if ({rmt_resp_vld, tour_resp_vld, resp} !== {2'b10, 8'h5A}) begin
            n_fail++;
            $display("FAIL rand_abort: got %b %h want 10 5a",
                     {rmt_resp_vld, tour_resp_vld}, resp);
          end
        end
      end
      rmt_vld = 1'b0; tour_vld = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    rmt_vld = 1'b0; rmt_cmd = '0;
    tour_vld = 1'b0; tour_cmd = '0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; tour_fin = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_tour_lock();
    test_timeout();
    test_fin_pending();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
